// File: rtl/uart_pkg.sv
// Shared definitions for the MMIO UART transmitter: register offsets, STATUS
// bit positions and the serializer state type.
package uart_pkg;

   localparam logic [1:0] REG_TXDATA  = 2'd0;
   localparam logic [1:0] REG_STATUS  = 2'd1;
   localparam logic [1:0] REG_DIVISOR = 2'd2;

   localparam int ST_FULL      = 0;
   localparam int ST_EMPTY     = 1;
   localparam int ST_BUSY      = 2;
   localparam int ST_OVERFLOW  = 3;
   localparam int ST_COUNT_LSB = 8;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } uart_state_e;

   // A divisor of zero would stall the baud counter, so it is promoted to one.
   function automatic logic [15:0] fixDivisor(input logic [15:0] value);
      return (value == 16'd0) ? 16'd1 : value;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head output; pushes while
// full and pops while empty are ignored.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic [WIDTH-1:0]         head
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wrPtr;
   logic [PTR_W-1:0] r_rdPtr;
   logic [CNT_W-1:0] r_count;
   logic             w_doPush;
   logic             w_doPop;

   assign w_doPush = push && !full;
   assign w_doPop  = pop && !empty;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_doPush) r_wrPtr <= r_wrPtr + PTR_W'(1);
         if (w_doPop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
         case ({w_doPush, w_doPop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_doPush) r_mem[r_wrPtr] <= din;
   end

   assign full  = (r_count == CNT_W'(DEPTH));
   assign empty = (r_count == '0);
   assign count = r_count;
   assign head  = r_mem[r_rdPtr];

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-bus responder exposing a TX FIFO, status and baud divisor in a
// 16-byte window, and serializing queued bytes as 8N1 frames on tx.
module mmio_uart_tx
   import uart_pkg::*;
#(
   parameter logic [31:0] BASE        = 32'h1000_0000,
   parameter int          FIFO_DEPTH  = 8,
   parameter logic [15:0] DEFAULT_DIV = 16'd16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [29:0] address,
   input  logic [31:0] memory_in,
   input  logic [3:0]  write_enable,
   output logic [31:0] memory_out,
   output logic        read_capable,
   output logic        write_capable,
   output logic        tx
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic             w_hit;
   logic [1:0]       w_offset;
   logic             w_txWrite;
   logic             w_push;
   logic             w_pop;
   logic             w_full;
   logic             w_empty;
   logic [CNT_W-1:0] w_count;
   logic [7:0]       w_head;
   logic             w_divWrite;
   logic [15:0]      w_divMerged;
   logic             w_clearOvf;
   logic [31:0]      w_status;
   logic             w_baudDone;
   logic             w_unusedBits;

   logic [15:0]      r_div;
   logic             r_overflow;
   uart_state_e      r_state;
   uart_state_e      w_nextState;
   logic [15:0]      r_baud;
   logic [15:0]      w_nextBaud;
   logic [2:0]       r_bitIdx;
   logic [2:0]       w_nextBitIdx;
   logic [7:0]       r_shift;
   logic [7:0]       w_nextShift;

   assign w_hit        = (address[29:2] == BASE[31:4]);
   assign w_offset     = address[1:0];
   assign w_txWrite    = w_hit && (w_offset == REG_TXDATA) && write_enable[0];
   assign w_push       = w_txWrite && !w_full;
   assign w_divWrite   = w_hit && (w_offset == REG_DIVISOR) && (|write_enable[1:0]);
   assign w_clearOvf   = w_hit && (w_offset == REG_STATUS) && write_enable[0]
                         && memory_in[ST_OVERFLOW];
   assign w_unusedBits = ^{memory_in[31:16], write_enable[3:2]};

   assign read_capable  = rst;
   assign write_capable = !w_full;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (w_push),
      .pop   (w_pop),
      .din   (memory_in[7:0]),
      .full  (w_full),
      .empty (w_empty),
      .count (w_count),
      .head  (w_head)
   );

   always_comb begin
      w_divMerged = r_div;
      if (write_enable[0]) w_divMerged[7:0]  = memory_in[7:0];
      if (write_enable[1]) w_divMerged[15:8] = memory_in[15:8];
   end

   // A write that finds the FIFO full is lost, even if a pop frees a slot at the same edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_div      <= DEFAULT_DIV;
         r_overflow <= 1'b0;
      end else begin
         if (w_divWrite)               r_div      <= fixDivisor(w_divMerged);
         if (w_txWrite && w_full)      r_overflow <= 1'b1;
         else if (w_clearOvf)          r_overflow <= 1'b0;
      end
   end

   always_comb begin
      w_status                         = '0;
      w_status[ST_FULL]                = w_full;
      w_status[ST_EMPTY]               = w_empty;
      w_status[ST_BUSY]                = (r_state != IDLE);
      w_status[ST_OVERFLOW]            = r_overflow;
      w_status[ST_COUNT_LSB +: CNT_W]  = w_count;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         memory_out <= '0;
      end else if (!w_hit) begin
         memory_out <= '0;
      end else begin
         case (w_offset)
            REG_STATUS:  memory_out <= w_status;
            REG_DIVISOR: memory_out <= {16'd0, r_div};
            default:     memory_out <= '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= IDLE;
         r_baud   <= '0;
         r_bitIdx <= '0;
         r_shift  <= '0;
      end else begin
         r_state  <= w_nextState;
         r_baud   <= w_nextBaud;
         r_bitIdx <= w_nextBitIdx;
         r_shift  <= w_nextShift;
      end
   end

   assign w_baudDone = (r_baud == 16'd0);

   // Every bit period reloads from the live divisor, so divisor writes land at the next bit.
   always_comb begin
      w_nextState  = r_state;
      w_nextBaud   = r_baud;
      w_nextBitIdx = r_bitIdx;
      w_nextShift  = r_shift;
      w_pop        = 1'b0;
      tx           = 1'b1;
      case (r_state)
         IDLE: begin
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_nextShift = w_head;
               w_nextBaud  = r_div - 16'd1;
               w_nextState = START;
            end
         end
         START: begin
            tx = 1'b0;
            if (w_baudDone) begin
               w_nextState  = DATA;
               w_nextBitIdx = 3'd0;
               w_nextBaud   = r_div - 16'd1;
            end else begin
               w_nextBaud = r_baud - 16'd1;
            end
         end
         DATA: begin
            tx = r_shift[0];
            if (w_baudDone) begin
               w_nextBaud  = r_div - 16'd1;
               w_nextShift = r_shift >> 1;
               if (r_bitIdx == 3'd7) w_nextState  = STOP;
               else                  w_nextBitIdx = r_bitIdx + 3'd1;
            end else begin
               w_nextBaud = r_baud - 16'd1;
            end
         end
         STOP: begin
            tx = 1'b1;
            if (w_baudDone) begin
               if (!w_empty) begin
                  w_pop       = 1'b1;
                  w_nextShift = w_head;
                  w_nextBaud  = r_div - 16'd1;
                  w_nextState = START;
               end else begin
                  w_nextState = IDLE;
               end
            end else begin
               w_nextBaud = r_baud - 16'd1;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: register-access vector table, hand-built
// frame sequences, and randomized traffic against a frame-position reference model.
module tb_mmio_uart_tx;

   localparam logic [31:0] BASE    = 32'h1000_0000;
   localparam int          DEPTH   = 8;
   localparam int          NUM_VEC = 20;

   logic        clk = 1'b0;
   logic        rst;
   logic [29:0] address;
   logic [31:0] memory_in;
   logic [3:0]  write_enable;
   logic [31:0] memory_out;
   logic        read_capable;
   logic        write_capable;
   logic        tx;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   typedef struct {
      logic [29:0] addr;
      logic [31:0] wdata;
      logic [3:0]  we;
      bit          checkRd;
      logic [31:0] expRd;
   } vec_t;

   vec_t vecTable [NUM_VEC];

   logic [7:0] mq [$];
   int         mFrameT;
   logic [7:0] mCur;
   int         mDiv;
   bit         mOvf;

   always #5 clk = ~clk;

   mmio_uart_tx #(
      .BASE        (BASE),
      .FIFO_DEPTH  (DEPTH),
      .DEFAULT_DIV (16'd16)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .address       (address),
      .memory_in     (memory_in),
      .write_enable  (write_enable),
      .memory_out    (memory_out),
      .read_capable  (read_capable),
      .write_capable (write_capable),
      .tx            (tx)
   );

   function automatic logic [29:0] regAddr(input logic [31:0] byteOffset);
      logic [31:0] a;
      a = BASE + byteOffset;
      return a[31:2];
   endfunction

   task automatic applyStimulus(input logic [29:0] a, input logic [31:0] d, input logic [3:0] we);
      address      = a;
      memory_in    = d;
      write_enable = we;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   task automatic busWrite(input logic [31:0] byteOffset, input logic [31:0] d, input logic [3:0] we);
      applyStimulus(regAddr(byteOffset), d, we);
      step();
      applyStimulus(30'd0, 32'd0, 4'd0);
   endtask

   // Reference model: a byte queue plus the position inside the current frame.
   task automatic modelReset();
      mq.delete();
      mFrameT = -1;
      mCur    = 8'd0;
      mDiv    = 16;
      mOvf    = 1'b0;
   endtask

   task automatic modelEdge(input bit doPush, input logic [7:0] b, input bit clr,
                            input bit divW, input int dv);
      bit preFull;
      preFull = (mq.size() == DEPTH);
      if (mFrameT < 0) begin
         if (mq.size() > 0) begin
            mCur    = mq.pop_front();
            mFrameT = 0;
         end
      end else if (mFrameT == 10 * mDiv - 1) begin
         if (mq.size() > 0) begin
            mCur    = mq.pop_front();
            mFrameT = 0;
         end else begin
            mFrameT = -1;
         end
      end else begin
         mFrameT++;
      end
      if (doPush) begin
         if (preFull) mOvf = 1'b1;
         else         mq.push_back(b);
      end
      if (clr)  mOvf = 1'b0;
      if (divW) mDiv = (dv == 0) ? 1 : dv;
   endtask

   function automatic logic modelTx();
      logic [9:0] fr;
      if (mFrameT < 0) return 1'b1;
      fr = {1'b1, mCur, 1'b0};
      return fr[mFrameT / mDiv];
   endfunction

   function automatic logic [31:0] modelStatus();
      logic [31:0] s;
      int          n;
      n       = mq.size();
      s       = '0;
      s[0]    = (n == DEPTH);
      s[1]    = (n == 0);
      s[2]    = (mFrameT >= 0);
      s[3]    = mOvf;
      s[11:8] = 4'(n);
      return s;
   endfunction

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [9:0]  frame10;
      logic [19:0] b2b;
      logic [7:0]  bval;
      logic [31:0] expStat;
      logic [31:0] rdata;
      logic [7:0]  rb;
      int          frameStart;
      int          k;
      int          r;
      int          wrThresh;
      int          kind;
      int          dv;
      bit          doPush;
      bit          clr;
      bit          divW;

      rst = 1'b0;
      applyStimulus(30'd0, 32'd0, 4'd0);
      repeat (3) step();
      checkOutput("reset_tx", tx, 32'd1);
      checkOutput("reset_memout", memory_out, 32'd0);
      checkOutput("reset_read_capable", read_capable, 32'd0);
      rst = 1'b1;
      step();
      checkOutput("read_capable_high", read_capable, 32'd1);
      checkOutput("write_capable_empty", write_capable, 32'd1);

      vecTable[0]  = '{regAddr(32'h4),  32'h0,         4'h0, 1'b1, 32'h002};
      vecTable[1]  = '{regAddr(32'h8),  32'h0,         4'h0, 1'b1, 32'h010};
      vecTable[2]  = '{regAddr(32'h8),  32'h1234,      4'h3, 1'b0, 32'h0};
      vecTable[3]  = '{regAddr(32'h8),  32'h0,         4'h0, 1'b1, 32'h1234};
      vecTable[4]  = '{regAddr(32'h8),  32'hAB00,      4'h2, 1'b0, 32'h0};
      vecTable[5]  = '{regAddr(32'h8),  32'h0,         4'h0, 1'b1, 32'hAB34};
      vecTable[6]  = '{regAddr(32'h8),  32'h0,         4'h3, 1'b0, 32'h0};
      vecTable[7]  = '{regAddr(32'h8),  32'h0,         4'h0, 1'b1, 32'h0001};
      vecTable[8]  = '{regAddr(32'h8),  32'hFFFF_0005, 4'hF, 1'b0, 32'h0};
      vecTable[9]  = '{regAddr(32'h8),  32'h0,         4'h0, 1'b1, 32'h0005};
      vecTable[10] = '{regAddr(32'hC),  32'h0,         4'h0, 1'b1, 32'h0};
      vecTable[11] = '{regAddr(32'h0),  32'h0,         4'h0, 1'b1, 32'h0};
      vecTable[12] = '{regAddr(32'h18), 32'h0,         4'h0, 1'b1, 32'h0};
      vecTable[13] = '{regAddr(32'h10), 32'h55,        4'h1, 1'b0, 32'h0};
      vecTable[14] = '{regAddr(32'h4),  32'h0,         4'h0, 1'b1, 32'h002};
      vecTable[15] = '{regAddr(32'h8),  32'h0004,      4'h1, 1'b0, 32'h0};
      vecTable[16] = '{regAddr(32'h8),  32'h0,         4'h0, 1'b1, 32'h0004};
      vecTable[17] = '{regAddr(32'hC),  32'hFFFF,      4'hF, 1'b0, 32'h0};
      vecTable[18] = '{regAddr(32'h8),  32'h0,         4'h0, 1'b1, 32'h0004};
      vecTable[19] = '{regAddr(32'h4),  32'h0,         4'h0, 1'b1, 32'h002};

      for (int i = 0; i < NUM_VEC; i++) begin
         applyStimulus(vecTable[i].addr, vecTable[i].wdata, vecTable[i].we);
         step();
         if (vecTable[i].checkRd)
            checkOutput($sformatf("vec%0d_read", i), memory_out, vecTable[i].expRd);
         checkOutput($sformatf("vec%0d_tx_idle", i), tx, 32'd1);
         checkOutput($sformatf("vec%0d_wcap", i), write_capable, 32'd1);
      end
      applyStimulus(30'd0, 32'd0, 4'd0);

      // Single 0xA5 frame with divisor 4, STATUS polled throughout.
      busWrite(32'h0, 32'hA5, 4'b0001);
      checkOutput("single_tx_before_pop", tx, 32'd1);
      frame10 = {1'b1, 8'hA5, 1'b0};
      applyStimulus(regAddr(32'h4), 32'h0, 4'h0);
      for (int j = 0; j < 40; j++) begin
         step();
         checkOutput($sformatf("single_k%0d", j), tx, 32'(frame10[j / 4]));
         if (j == 20) checkOutput("single_status_busy", memory_out, 32'h006);
      end
      step();
      checkOutput("single_tx_after_frame", tx, 32'd1);
      step();
      checkOutput("single_status_after", memory_out, 32'h002);
      applyStimulus(30'd0, 32'd0, 4'd0);

      // Back-to-back 0x00 / 0xFF frames with divisor 2.
      busWrite(32'h8, 32'h2, 4'b0011);
      b2b = {1'b1, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b0};
      applyStimulus(regAddr(32'h0), 32'h00, 4'b0001);
      step();
      checkOutput("b2b_tx_before_pop", tx, 32'd1);
      applyStimulus(regAddr(32'h0), 32'hFF, 4'b0001);
      step();
      checkOutput("b2b_k0", tx, 32'(b2b[0]));
      applyStimulus(30'd0, 32'd0, 4'd0);
      for (int j = 1; j < 40; j++) begin
         step();
         checkOutput($sformatf("b2b_k%0d", j), tx, 32'(b2b[j / 2]));
      end
      applyStimulus(regAddr(32'h4), 32'h0, 4'h0);
      step();
      checkOutput("b2b_tx_after", tx, 32'd1);
      step();
      checkOutput("b2b_status_after", memory_out, 32'h002);
      applyStimulus(30'd0, 32'd0, 4'd0);

      // Fill the FIFO past capacity with divisor 100.
      busWrite(32'h8, 32'd100, 4'b0011);
      frameStart = 0;
      for (int i = 0; i < 10; i++) begin
         applyStimulus(regAddr(32'h0), 32'h10 + 32'(i), 4'b0001);
         step();
         if (i == 0) checkOutput("fill_tx_before_pop", tx, 32'd1);
         if (i == 1) begin
            checkOutput("fill_tx_start", tx, 32'd0);
            frameStart = cyc;
         end
         if (i >= 8) checkOutput($sformatf("fill_wcap_full%0d", i), write_capable, 32'd0);
         else        checkOutput($sformatf("fill_wcap_open%0d", i), write_capable, 32'd1);
      end
      applyStimulus(regAddr(32'h4), 32'h0, 4'h0);
      step();
      checkOutput("fill_status_overflow", memory_out, 32'h80D);
      busWrite(32'h4, 32'h8, 4'b0001);
      applyStimulus(regAddr(32'h4), 32'h0, 4'h0);
      step();
      checkOutput("fill_status_cleared", memory_out, 32'h805);
      applyStimulus(30'd0, 32'd0, 4'd0);
      while ((cyc - frameStart) < 9000) begin
         step();
         k = cyc - frameStart;
         if ((k % 100) == 50) begin
            bval    = 8'(16 + k / 1000);
            frame10 = {1'b1, bval, 1'b0};
            checkOutput($sformatf("fill_frame%0d_bit%0d", k / 1000, (k % 1000) / 100),
                        tx, 32'(frame10[(k % 1000) / 100]));
         end
      end
      checkOutput("fill_tx_idle_end", tx, 32'd1);
      checkOutput("fill_wcap_end", write_capable, 32'd1);
      applyStimulus(regAddr(32'h4), 32'h0, 4'h0);
      step();
      checkOutput("fill_status_end", memory_out, 32'h002);
      applyStimulus(30'd0, 32'd0, 4'd0);

      // Reset in the middle of data bit 3 with bytes still queued.
      busWrite(32'h8, 32'd8, 4'b0011);
      applyStimulus(regAddr(32'h0), 32'h00, 4'b0001);
      step();
      applyStimulus(regAddr(32'h0), 32'h11, 4'b0001);
      step();
      frameStart = cyc;
      applyStimulus(regAddr(32'h0), 32'h22, 4'b0001);
      step();
      applyStimulus(30'd0, 32'd0, 4'd0);
      while ((cyc - frameStart) < 35) step();
      checkOutput("rstmid_tx_low_before", tx, 32'd0);
      rst = 1'b0;
      #1;
      checkOutput("rstmid_tx_high", tx, 32'd1);
      checkOutput("rstmid_wcap", write_capable, 32'd1);
      checkOutput("rstmid_memout", memory_out, 32'd0);
      repeat (2) step();
      rst = 1'b1;
      applyStimulus(regAddr(32'h4), 32'h0, 4'h0);
      step();
      checkOutput("rstmid_status", memory_out, 32'h002);
      applyStimulus(regAddr(32'h8), 32'h0, 4'h0);
      step();
      checkOutput("rstmid_divisor", memory_out, 32'd16);
      applyStimulus(30'd0, 32'd0, 4'd0);
      for (int j = 0; j < 200; j++) begin
         step();
         checkOutput("rstmid_tx_quiet", tx, 32'd1);
      end

      // Randomized traffic against the reference model.
      modelReset();
      applyStimulus(regAddr(32'h8), 32'd2, 4'b0011);
      step();
      modelEdge(1'b0, 8'd0, 1'b0, 1'b1, 2);
      for (int n = 0; n < 3000; n++) begin
         wrThresh = (((n / 200) % 2) == 0) ? 50 : 4;
         r        = int'($urandom_range(0, 99));
         expStat  = modelStatus();
         doPush   = 1'b0;
         clr      = 1'b0;
         divW     = 1'b0;
         kind     = 0;
         rb       = 8'd0;
         dv       = 0;
         if (r < wrThresh) begin
            rb = 8'($urandom_range(0, 255));
            applyStimulus(regAddr(32'h0), {24'd0, rb}, 4'b0001);
            doPush = 1'b1;
         end else if (r < wrThresh + 20) begin
            applyStimulus(regAddr(32'h4), 32'h0, 4'h0);
            kind = 1;
         end else if (r < wrThresh + 25) begin
            rdata = $urandom;
            applyStimulus(regAddr(32'h4), rdata, 4'b0001);
            clr = rdata[3];
         end else if ((r < wrThresh + 35) && (mFrameT < 0) && (mq.size() == 0)) begin
            dv = int'($urandom_range(0, 3));
            applyStimulus(regAddr(32'h8), 32'(dv), 4'b0011);
            divW = 1'b1;
         end else begin
            applyStimulus(regAddr(32'hC), 32'h0, 4'h0);
            kind = 2;
         end
         step();
         modelEdge(doPush, rb, clr, divW, dv);
         checkOutput("rand_tx", tx, 32'(modelTx()));
         checkOutput("rand_wcap", write_capable, 32'(mq.size() < DEPTH));
         if (kind == 1) checkOutput("rand_status", memory_out, expStat);
         if (kind == 2) checkOutput("rand_reserved", memory_out, 32'd0);
      end
      applyStimulus(30'd0, 32'd0, 4'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
